codec_stream_scheduler: RTL

- Sequences sample transfers between the CODEC interface's mic-in (read side) and line-out (write side).
- Decouples the two sides with a small sample-pair FIFO.
- Primes the FIFO to a configured level before playback starts. Detects overflow and underflow.
- Sits between the CODEC interface and any downstream audio processing. Generates all read/write strobes.

---
 rtl/codec_stream_scheduler.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/codec_stream_scheduler.sv
// codec_stream_scheduler
//   Moves left/right sample pairs from the CODEC mic-in side to the line-out
//   side through a small first-word-fall-through FIFO. Playback is held off
//   until the FIFO has primed to PRIME_LEVEL pairs. Overflow (sample dropped
//   while full) and underflow (line-out slot with an empty FIFO while
//   playing) are reported as one-cycle pulses.
//
// Parameters
//   DATA_W       sample width per channel
//   DEPTH        FIFO depth in sample pairs (power of two, >= 2)
//   PRIME_LEVEL  pairs buffered before playback starts (1..DEPTH)
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   enable            streaming enable; low flushes the FIFO and re-primes
//   mute              zero the line-out data while still consuming samples
//   read_ready        CODEC has a mic-in sample (readdata_left/right)
//   write_ready       CODEC can take a line-out sample
//   read, write       combinational consume/produce strobes to the CODEC
//   writedata_*       line-out sample pair (zero when not popping or muted)
//   fill_level        pairs currently held in the FIFO
//   playing           high while in RUN
//   overflow          one-cycle pulse: mic-in sample discarded, FIFO full
//   underflow         one-cycle pulse: line-out slot with an empty FIFO
//
// Optional build macro
//   DROP_COUNT_EN     adds drop_count[15:0], a saturating count of overflow
//                     and underflow events (cleared by reset and enable=0)
module codec_stream_scheduler #(
  parameter int DATA_W      = 24,
  parameter int DEPTH       = 8,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       mute,
  input  logic                       read_ready,
  input  logic                       write_ready,
  input  logic [DATA_W-1:0]          readdata_left,
  input  logic [DATA_W-1:0]          readdata_right,
  output logic                       read,
  output logic                       write,
  output logic [DATA_W-1:0]          writedata_left,
  output logic [DATA_W-1:0]          writedata_right,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       playing,
  output logic                       overflow,
  output logic                       underflow
`ifdef DROP_COUNT_EN
  ,
  output logic [15:0]                drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] PRIME_CNT = (AW+1)'(PRIME_LEVEL);
  localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR = AW'(1);

  typedef enum logic {PRIME, RUN} state_t;

  state_t                  state, state_next;
  logic [2*DATA_W-1:0]     mem [DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count, count_next;
  logic                    full, empty;
  logic                    push, pop;
  logic                    drop, underrun;
  logic                    overflow_p1, underflow_p1;
  logic [2*DATA_W-1:0]     head;

`ifdef DROP_COUNT_EN
  logic [15:0]             drop_count_p1;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
`endif

  // Strobes and FIFO handshakes, all combinational from registered state
  assign read     = enable & read_ready;
  assign write    = enable & write_ready;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop      = write & (state == RUN) & ~empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push     = read & (~full | pop);
  assign drop     = read & full & ~pop;
  assign underrun = write & (state == RUN) & empty;
  assign head     = mem[rd_ptr];

  assign {writedata_left, writedata_right} = (pop && !mute) ? head : '0;

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + ONE_CNT;
      2'b01:   count_next = count - ONE_CNT;
      default: count_next = count;
    endcase
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = PRIME;
    end else begin
      unique case (state)
        PRIME:   if (count_next >= PRIME_CNT) state_next = RUN;
        RUN:     if (underrun) state_next = PRIME;
        default: state_next = PRIME;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= PRIME;
    else       state <= state_next;
  end

  // Stage p0 -> p1: FIFO control and event pulses
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_p1  <= 1'b0;
      underflow_p1 <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
      count        <= count_next;
      overflow_p1  <= drop;
      underflow_p1 <= underrun;
    end
  end

  // Sample storage; pointers alone define validity, so no reset here
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {readdata_left, readdata_right};
  end

`ifdef DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset || !enable) drop_count_p1 <= '0;
    else                  drop_count_p1 <= sat_add16(drop_count_p1, {1'b0, drop} + {1'b0, underrun});
  end
  assign drop_count = drop_count_p1;
`endif

  assign fill_level = count;
  assign playing    = (state == RUN);
  assign overflow   = overflow_p1;
  assign underflow  = underflow_p1;

endmodule
